// File: rtl/cms_trace_receiver_if.sv
// Trace-stream bundle: AXI-Stream beat input plus unpacked head-of-FIFO output.
// master = producer/consumer side, slave = receiver.
interface cms_trace_receiver_if #(
  parameter int XLEN = 64
);
  localparam int AXI_DATA_WIDTH = XLEN + 32;

  logic                      S_AXIS_tvalid;
  logic                      S_AXIS_tready;
  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata;
  logic                      S_AXIS_tlast;

  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_pc;
  logic [31:0]               out_instr;
  logic                      out_last;

  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
    input  S_AXIS_tready, out_valid, out_pc, out_instr, out_last
  );

  modport slave (
    input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
    output S_AXIS_tready, out_valid, out_pc, out_instr, out_last
  );
endinterface

// File: rtl/cms_trace_receiver.sv
// Trace-stream receiver: FWFT FIFO, packet-length checker, stats counters.
// Optional CMS_RX_PC_CHECK_EN adds pc_disc_count (pc != prev+4 counter).
module cms_trace_receiver #(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = XLEN + 32,
  parameter int DEPTH          = 8
) (
  input  logic        clk,
  input  logic        rst,
  cms_trace_receiver_if.slave axis,
  input  logic [31:0] tlast_interval,
  input  logic        clear_stats,
  output logic [31:0] beat_count,
  output logic [31:0] packet_count,
  output logic        len_err,
  output logic        in_packet
`ifdef CMS_RX_PC_CHECK_EN
  ,
  output logic [31:0] pc_disc_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  logic [AXI_DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [AXI_DATA_WIDTH:0] head;

  state_t      state;
  logic [31:0] beat_idx;
  logic [31:0] k;
  logic        bad;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = axis.S_AXIS_tvalid && !full;
  assign pop   = !empty && axis.out_ready;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign axis.S_AXIS_tready = !full;
  assign axis.out_valid     = !empty;
  assign axis.out_pc    = empty ? '0 : head[XLEN-1:0];
  assign axis.out_instr = empty ? '0 : head[XLEN+31:XLEN];
  assign axis.out_last  = empty ? 1'b0 : head[AXI_DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {axis.S_AXIS_tlast, axis.S_AXIS_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // k is the 1-based index of the beat being accepted now
  assign k   = (beat_idx == '1) ? beat_idx : beat_idx + 32'd1;
  assign bad = (tlast_interval != 32'd0) &&
               (axis.S_AXIS_tlast ? (k != tlast_interval)
                                  : (k == tlast_interval));

  assign in_packet = (state == RECV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_idx <= '0;
    end else if (push) begin
      if (axis.S_AXIS_tlast) begin
        state    <= IDLE;
        beat_idx <= '0;
      end else begin
        state    <= RECV;
        beat_idx <= k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count   <= '0;
      packet_count <= '0;
      len_err      <= 1'b0;
    end else if (clear_stats) begin
      beat_count   <= '0;
      packet_count <= '0;
      len_err      <= 1'b0;
    end else if (push) begin
      if (beat_count != '1)
        beat_count <= beat_count + 32'd1;
      if (axis.S_AXIS_tlast && packet_count != '1)
        packet_count <= packet_count + 32'd1;
      if (bad)
        len_err <= 1'b1;
    end
  end

`ifdef CMS_RX_PC_CHECK_EN
  logic [XLEN-1:0] prev_pc;
  logic            have_prev;
  logic [XLEN-1:0] cur_pc;

  assign cur_pc = axis.S_AXIS_tdata[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc       <= '0;
      have_prev     <= 1'b0;
      pc_disc_count <= '0;
    end else if (clear_stats) begin
      have_prev     <= 1'b0;
      pc_disc_count <= '0;
    end else if (push) begin
      if (have_prev && cur_pc != prev_pc + XLEN'(4) &&
          pc_disc_count != '1)
        pc_disc_count <= pc_disc_count + 32'd1;
      prev_pc   <= cur_pc;
      have_prev <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cms_trace_receiver.sv
// Directed bench for cms_trace_receiver with a scoreboard on the output port.
// Define CMS_RX_PC_CHECK_EN to also exercise pc_disc_count.
module tb_cms_trace_receiver;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tlast_interval;
  logic        clear_stats;
  logic [31:0] beat_count;
  logic [31:0] packet_count;
  logic        len_err;
  logic        in_packet;
`ifdef CMS_RX_PC_CHECK_EN
  logic [31:0] pc_disc_count;
`endif

  int   npass  = 0;
  int   ntotal = 0;
  exp_t q[$];

  cms_trace_receiver_if #(.XLEN(XLEN)) bus ();

  cms_trace_receiver #(
    .XLEN(XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .axis           (bus.slave),
    .tlast_interval (tlast_interval),
    .clear_stats    (clear_stats),
    .beat_count     (beat_count),
    .packet_count   (packet_count),
    .len_err        (len_err),
    .in_packet      (in_packet)
`ifdef CMS_RX_PC_CHECK_EN
    ,
    .pc_disc_count  (pc_disc_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Pop happens at the coming posedge; inputs only move at posedge+1
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_pop", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_pc", bus.out_pc, e.pc);
        chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
        chk("out_last", 64'(bus.out_last), 64'(e.last));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic send(input logic [XLEN-1:0] pc, input logic last);
    logic [31:0] ins;
    logic        rdy;
    bit          ok;
    ins = $urandom;
    ok  = 0;
    bus.S_AXIS_tvalid = 1'b1;
    bus.S_AXIS_tdata  = {ins, pc};
    bus.S_AXIS_tlast  = last;
    q.push_back({pc, ins, last});
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      rdy = bus.S_AXIS_tready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
    end
    if (!ok) begin
      chk("send_timeout", 64'd0, 64'd1);
      void'(q.pop_back());
    end
    bus.S_AXIS_tvalid = 1'b0;
    bus.S_AXIS_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || bus.out_valid); i++)
      sync();
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic clear();
    clear_stats = 1'b1;
    sync();
    clear_stats = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    tlast_interval    = 32'd4;
    clear_stats       = 1'b0;
    bus.S_AXIS_tvalid = 1'b0;
    bus.S_AXIS_tdata  = '0;
    bus.S_AXIS_tlast  = 1'b0;
    bus.out_ready     = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    chk("rst_tready", 64'(bus.S_AXIS_tready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    chk("rst_packet_count", 64'(packet_count), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_in_packet", 64'(in_packet), 64'd0);

    // two well-formed 4-beat packets
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(64'(8 + 4 * i), (i % 4) == 3);
    drain();
    chk("t1_packet_count", 64'(packet_count), 64'd2);
    chk("t1_beat_count", 64'(beat_count), 64'd8);
    chk("t1_len_err", 64'(len_err), 64'd0);
    chk("t1_in_packet", 64'(in_packet), 64'd0);

    // backpressure with length check off
    tlast_interval = 32'd0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 8; i++)
      send(64'(32'h1000 + 4 * i), 1'b0);
    chk("t2_tready_full", 64'(bus.S_AXIS_tready), 64'd0);
    chk("t2_head_pc", bus.out_pc, 64'h1000);
    idle(2);
    chk("t2_tready_hold", 64'(bus.S_AXIS_tready), 64'd0);
    chk("t2_head_hold", bus.out_pc, 64'h1000);
    bus.out_ready = 1'b1;
    send(64'h1020, 1'b0);
    send(64'h1024, 1'b1);
    drain();
    chk("t2_beat_count", 64'(beat_count), 64'd18);
    chk("t2_packet_count", 64'(packet_count), 64'd3);
    chk("t2_len_err", 64'(len_err), 64'd0);

    // short packet, clear, then good packet
    tlast_interval = 32'd4;
    clear();
    send(64'h2000, 1'b0);
    send(64'h2004, 1'b0);
    send(64'h2008, 1'b1);
    chk("t3_len_err_short", 64'(len_err), 64'd1);
    chk("t3_packet_count", 64'(packet_count), 64'd1);
    clear();
    chk("t3_clr_len_err", 64'(len_err), 64'd0);
    chk("t3_clr_beat", 64'(beat_count), 64'd0);
    chk("t3_clr_packet", 64'(packet_count), 64'd0);
    for (int i = 0; i < 4; i++)
      send(64'(32'h3000 + 4 * i), i == 3);
    chk("t3_good_len_err", 64'(len_err), 64'd0);
    chk("t3_good_beat", 64'(beat_count), 64'd4);
    chk("t3_good_packet", 64'(packet_count), 64'd1);

    // clear_stats beats a same-cycle bad 1-beat packet
    clear_stats = 1'b1;
    send(64'h3800, 1'b1);
    clear_stats = 1'b0;
    chk("t3b_len_err", 64'(len_err), 64'd0);
    chk("t3b_beat", 64'(beat_count), 64'd0);
    chk("t3b_packet", 64'(packet_count), 64'd0);
    chk("t3b_in_packet", 64'(in_packet), 64'd0);
    drain();

    // overlong packet
    for (int i = 0; i < 6; i++) begin
      send(64'(32'h4000 + 4 * i), i == 5);
      if (i == 2) chk("t4_len_err_b3", 64'(len_err), 64'd0);
      if (i == 3) chk("t4_len_err_b4", 64'(len_err), 64'd1);
      if (i == 4) chk("t4_in_packet_b5", 64'(in_packet), 64'd1);
    end
    chk("t4_in_packet_end", 64'(in_packet), 64'd0);
    chk("t4_packet_count", 64'(packet_count), 64'd1);
    chk("t4_beat_count", 64'(beat_count), 64'd6);
    drain();

    // reset mid-packet with 3 entries queued
    bus.out_ready = 1'b0;
    send(64'h5000, 1'b0);
    send(64'h5004, 1'b0);
    send(64'h5008, 1'b0);
    chk("t5_in_packet", 64'(in_packet), 64'd1);
    chk("t5_out_valid_pre", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_tready", 64'(bus.S_AXIS_tready), 64'd1);
    chk("t5_beat_count", 64'(beat_count), 64'd0);
    chk("t5_packet_count", 64'(packet_count), 64'd0);
    chk("t5_in_packet_rst", 64'(in_packet), 64'd0);
    q.delete();
    sync();
    rst = 1'b0;
    sync();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(64'(32'h6000 + 4 * i), i == 3);
    drain();
    chk("t5_after_len_err", 64'(len_err), 64'd0);
    chk("t5_after_packet", 64'(packet_count), 64'd1);
    chk("t5_after_beat", 64'(beat_count), 64'd4);

`ifdef CMS_RX_PC_CHECK_EN
    clear();
    tlast_interval = 32'd5;
    send(64'd4, 1'b0);
    send(64'd8, 1'b0);
    send(64'd12, 1'b0);
    send(64'd100, 1'b0);
    send(64'd104, 1'b1);
    drain();
    chk("t6_pc_disc", 64'(pc_disc_count), 64'd1);
    chk("t6_len_err", 64'(len_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
